// File: rtl/time_frame_tx_if.sv
// Byte-stream link from the time frame generator to the UART TX FIFO.
//   tx_data  : current frame byte (master -> slave)
//   tx_valid : tx_data holds a byte (master -> slave)
//   tx_ready : slave accepts the byte (slave -> master)
// Handshake: a byte transfers on a rising clk edge where tx_valid & tx_ready.
// Once tx_valid is raised, it and tx_data stay unchanged until that transfer
// happens. The only exception is reset.
interface time_frame_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/time_frame_tx.sv
// time_frame_tx: snapshots a packed BCD time value on a trigger and streams
// one ASCII frame such as "SW 12:34:56\n" byte by byte to the UART TX FIFO.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   sw_mode      : 0 -> prefix "SW", 1 -> prefix "CL"
//   start        : single-cycle frame request
//   auto_en      : lets tick_period trigger frames
//   tick_period  : single-cycle periodic trigger
//   digits       : NUM_FIELDS packed BCD fields; field 0 is in the top byte
//   tx           : byte stream master (tx_data / tx_valid / tx_ready)
//   busy         : frame in progress
//   frame_done   : one-cycle pulse after the last byte is accepted
//   overrun      : one-cycle pulse when a trigger arrives during a frame
//   dbg_state_o  : FSM state (0 = IDLE, 1 = SEND)
module time_frame_tx #(
  parameter int          DATA_WIDTH = 8,
  parameter int          NUM_FIELDS = 3,
  parameter int          CR_EN      = 0,
  parameter logic [7:0]  SEP_CHAR   = 8'h3A
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sw_mode,
  input  logic                    start,
  input  logic                    auto_en,
  input  logic                    tick_period,
  input  logic [NUM_FIELDS*8-1:0] digits,
  time_frame_tx_if.master         tx,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    overrun,
  output logic                    dbg_state_o
);

  localparam int FRAME_LEN = 3 * NUM_FIELDS + 3 + CR_EN;
  localparam int IDX_W     = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_e;

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [NUM_FIELDS*8-1:0]   digits_q, digits_d;
  logic                      mode_q, mode_d;
  logic                      done_q, done_d;
  logic                      ovr_q, ovr_d;

  logic                      trig_w;
  logic                      hs_w;
  logic [FRAME_LEN*8-1:0]    frame_w;
  logic [7:0]                byte_w;

  function automatic logic [7:0] ascii_digit(input logic [3:0] n);
    return (n > 4'd9) ? 8'h3F : {4'h3, n};
  endfunction

  assign trig_w = start | (auto_en & tick_period);
  assign hs_w   = (state_q == S_SEND) & tx.tx_ready;

  // Whole frame laid out from the snapshot only; byte 0 sits in bits [7:0].
  // Because only registered values feed it, input changes mid-frame cannot
  // tear the text.
  always_comb begin
    frame_w         = '0;
    frame_w[7:0]    = mode_q ? 8'h43 : 8'h53;
    frame_w[15:8]   = mode_q ? 8'h4C : 8'h57;
    frame_w[23:16]  = 8'h20;
    for (int k = 0; k < NUM_FIELDS; k++) begin
      frame_w[(3 + 3*k)*8 +: 8] = ascii_digit(digits_q[(NUM_FIELDS-1-k)*8 + 4 +: 4]);
      frame_w[(4 + 3*k)*8 +: 8] = ascii_digit(digits_q[(NUM_FIELDS-1-k)*8 +: 4]);
      if (k < NUM_FIELDS - 1) begin
        frame_w[(5 + 3*k)*8 +: 8] = SEP_CHAR;
      end
    end
    if (CR_EN != 0) begin
      frame_w[(FRAME_LEN-2)*8 +: 8] = 8'h0D;
    end
    frame_w[(FRAME_LEN-1)*8 +: 8] = 8'h0A;
  end

  assign byte_w = frame_w[idx_q*8 +: 8];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      digits_q <= '0;
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      digits_q <= digits_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    digits_d = digits_q;
    mode_d   = mode_q;
    done_d   = 1'b0;
    ovr_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trig_w) begin
          state_d  = S_SEND;
          idx_d    = '0;
          digits_d = digits;
          mode_d   = sw_mode;
        end
      end
      S_SEND: begin
        // A trigger during a frame is dropped, never queued.
        ovr_d = trig_w;
        if (hs_w) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    tx.tx_valid = (state_q == S_SEND);
    tx.tx_data  = (state_q == S_SEND) ? DATA_WIDTH'(byte_w) : '0;
    busy        = (state_q == S_SEND);
    frame_done  = done_q;
    overrun     = ovr_q;
    dbg_state_o = state_q;
  end

endmodule
